// File: rtl/xmem_split.sv
// xmem_split: single-master to multi-slave address router for the xmem protocol.
// Requests are decoded and forwarded combinationally. Read responses are
// registered and returned in request order. Unmapped addresses are answered
// locally with a decode error so the bus never hangs.
module xmem_split #(
  parameter int unsigned NUM_SLAVES      = 2,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = {32'h0001_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {32'hFFFF_0000, 32'hFFFF_0000},
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [DATA_WIDTH-1:0] DECERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                                  aclk,
  input  logic                                  areset,
  input  logic                                  s_req_valid,
  output logic                                  s_req_ready,
  input  logic                                  s_req_we,
  input  logic [ADDR_WIDTH-1:0]                 s_req_addr,
  input  logic [DATA_WIDTH-1:0]                 s_req_wdata,
  output logic                                  s_rsp_valid,
  output logic [DATA_WIDTH-1:0]                 s_rsp_rdata,
  output logic [NUM_SLAVES-1:0]                 m_req_valid,
  input  logic [NUM_SLAVES-1:0]                 m_req_ready,
  output logic                                  m_req_we,
  output logic [ADDR_WIDTH-1:0]                 m_req_addr,
  output logic [DATA_WIDTH-1:0]                 m_req_wdata,
  input  logic [NUM_SLAVES-1:0]                 m_rsp_valid,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0]      m_rsp_rdata,
  output logic                                  decerr,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]  outstanding
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SLV_W = $clog2(NUM_SLAVES + 1);
  localparam logic [SLV_W-1:0] DECERR_SLOT = SLV_W'(NUM_SLAVES);

  // Read tracking and response registers
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  logic [SLV_W-1:0]      cur_slv_q,   cur_slv_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  decerr_q,    decerr_d;

  // Decode / datapath helpers
  logic [SLV_W-1:0]      sel;
  logic                  hit_any;
  logic                  sel_ready;
  logic                  cur_rsp_valid;
  logic [DATA_WIDTH-1:0] cur_rsp_rdata;
  logic                  stall;
  logic                  req_hs;
  logic                  rd_acc;
  logic                  rsp_hit;

  // Address decode: lowest matching slave index wins, no match selects the decode-error slot
  always_comb begin
    sel     = DECERR_SLOT;
    hit_any = 1'b0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (!hit_any &&
          ((s_req_addr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
           SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        hit_any = 1'b1;
        sel     = SLV_W'(i);
      end
    end
  end

  // Slave-side muxes: ready of the selected slave, response of the slave owning the in-flight reads
  always_comb begin
    sel_ready     = 1'b1;
    cur_rsp_valid = 1'b0;
    cur_rsp_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (sel == SLV_W'(i)) begin
        sel_ready = m_req_ready[i];
      end
      if (cur_slv_q == SLV_W'(i)) begin
        cur_rsp_valid = m_rsp_valid[i];
        cur_rsp_rdata = m_rsp_rdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Request path: read ordering stall, handshake, fan-out of valid
  always_comb begin
    stall = !s_req_we &&
            ((cnt_q == CNT_W'(MAX_OUTSTANDING)) ||
             ((cnt_q != '0) && ((sel != cur_slv_q) || !hit_any)));
    s_req_ready = !areset && !stall && sel_ready;
    req_hs      = s_req_valid && s_req_ready;
    rd_acc      = req_hs && !s_req_we;
    m_req_valid = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      m_req_valid[i] = s_req_valid && !areset && !stall && (sel == SLV_W'(i));
    end
    m_req_we    = s_req_we;
    m_req_addr  = s_req_addr;
    m_req_wdata = s_req_wdata;
  end

  // Next-state for read tracking and the registered response path
  always_comb begin
    rsp_hit = (cnt_q != '0) && cur_rsp_valid;

    cnt_d = cnt_q;
    if (rd_acc && hit_any) cnt_d = cnt_d + CNT_W'(1);
    if (rsp_hit)           cnt_d = cnt_d - CNT_W'(1);

    cur_slv_d = rd_acc ? sel : cur_slv_q;

    // A decode-error read is answered in its own accept cycle, so it never
    // occupies the counter; it only accepts with cnt == 0, hence no overlap
    // with a slave response.
    rsp_valid_d = rsp_hit || (rd_acc && !hit_any);
    if (rd_acc && !hit_any) begin
      rsp_rdata_d = DECERR_DATA;
    end else if (rsp_hit) begin
      rsp_rdata_d = cur_rsp_rdata;
    end else begin
      rsp_rdata_d = '0;
    end

    decerr_d = req_hs && !hit_any;
  end

  // State registers with asynchronous reset
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt_q       <= '0;
      cur_slv_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      decerr_q    <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      cur_slv_q   <= cur_slv_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      decerr_q    <= decerr_d;
    end
  end

  assign s_rsp_valid = rsp_valid_q;
  assign s_rsp_rdata = rsp_rdata_q;
  assign decerr      = decerr_q;
  assign outstanding = cnt_q;

endmodule

// File: tb/tb_xmem_split.sv
// Directed self-checking bench for xmem_split (2 slaves, default map).
// Inputs are driven on the falling edge; outputs are sampled 1ns later.
module tb_xmem_split;

  logic        aclk = 1'b0;
  logic        areset;
  logic        s_req_valid;
  logic        s_req_ready;
  logic        s_req_we;
  logic [31:0] s_req_addr;
  logic [31:0] s_req_wdata;
  logic        s_rsp_valid;
  logic [31:0] s_rsp_rdata;
  logic [1:0]  m_req_valid;
  logic [1:0]  m_req_ready;
  logic        m_req_we;
  logic [31:0] m_req_addr;
  logic [31:0] m_req_wdata;
  logic [1:0]  m_rsp_valid;
  logic [63:0] m_rsp_rdata;
  logic        decerr;
  logic [2:0]  outstanding;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  xmem_split #(
    .NUM_SLAVES      (2),
    .DATA_WIDTH      (32),
    .ADDR_WIDTH      (32),
    .MAX_OUTSTANDING (4)
  ) dut (
    .aclk        (aclk),
    .areset      (areset),
    .s_req_valid (s_req_valid),
    .s_req_ready (s_req_ready),
    .s_req_we    (s_req_we),
    .s_req_addr  (s_req_addr),
    .s_req_wdata (s_req_wdata),
    .s_rsp_valid (s_rsp_valid),
    .s_rsp_rdata (s_rsp_rdata),
    .m_req_valid (m_req_valid),
    .m_req_ready (m_req_ready),
    .m_req_we    (m_req_we),
    .m_req_addr  (m_req_addr),
    .m_req_wdata (m_req_wdata),
    .m_rsp_valid (m_rsp_valid),
    .m_rsp_rdata (m_rsp_rdata),
    .decerr      (decerr),
    .outstanding (outstanding)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Advance to the next falling edge (drive point).
  task automatic fall();
    @(negedge aclk);
  endtask

  task automatic req(input logic v, input logic we, input logic [31:0] a, input logic [31:0] d);
    s_req_valid = v;
    s_req_we    = we;
    s_req_addr  = a;
    s_req_wdata = d;
  endtask

  task automatic rsp(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1);
    m_rsp_valid = v;
    m_rsp_rdata = {d1, d0};
  endtask

  initial begin
    areset      = 1'b1;
    m_req_ready = 2'b11;
    req(1'b1, 1'b0, 32'h0, 32'h0);
    rsp(2'b00, 32'h0, 32'h0);
    #1;
    // Reset state
    chk("rst_rsp_valid", s_rsp_valid, 0);
    chk("rst_rsp_rdata", s_rsp_rdata, 0);
    chk("rst_decerr", decerr, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_req_ready", s_req_ready, 0);
    chk("rst_m_req_valid", m_req_valid, 0);

    fall();
    areset = 1'b0;
    req(1'b0, 1'b0, 32'h0, 32'h0);

    // 1: write then read slave0
    fall();
    req(1'b1, 1'b1, 32'h0000_0004, 32'hBADA_55E5);
    #1;
    chk("t1_wr_mvalid", m_req_valid, 2'b01);
    chk("t1_wr_ready", s_req_ready, 1);
    chk("t1_wr_wdata", m_req_wdata, 32'hBADA_55E5);
    chk("t1_wr_we", m_req_we, 1);
    fall();
    req(1'b1, 1'b0, 32'h0000_0004, 32'h0);
    #1;
    chk("t1_rd_mvalid", m_req_valid, 2'b01);
    chk("t1_rd_ready", s_req_ready, 1);
    chk("t1_wr_no_cnt", outstanding, 0);
    fall();
    req(1'b0, 1'b0, 32'h0, 32'h0);
    rsp(2'b01, 32'hBADA_55E5, 32'h0);
    #1;
    chk("t1_out1", outstanding, 1);
    chk("t1_no_rsp_yet", s_rsp_valid, 0);
    fall();
    rsp(2'b00, 32'h0, 32'h0);
    #1;
    chk("t1_rsp_valid", s_rsp_valid, 1);
    chk("t1_rsp_rdata", s_rsp_rdata, 32'hBADA_55E5);
    chk("t1_out0", outstanding, 0);
    fall();
    #1;
    chk("t1_rsp_pulse", s_rsp_valid, 0);

    // 2: slave1 read then slave0 read is held until slave1 answers
    fall();
    req(1'b1, 1'b0, 32'h0001_0008, 32'h0);
    #1;
    chk("t2_s1_mvalid", m_req_valid, 2'b10);
    chk("t2_s1_ready", s_req_ready, 1);
    fall();
    req(1'b1, 1'b0, 32'h0000_0000, 32'h0);
    #1;
    chk("t2_hold_ready", s_req_ready, 0);
    chk("t2_hold_mvalid", m_req_valid, 2'b00);
    fall();
    rsp(2'b10, 32'h0, 32'h1111_1111);
    #1;
    chk("t2_hold2_ready", s_req_ready, 0);
    fall();
    rsp(2'b00, 32'h0, 32'h0);
    #1;
    chk("t2_rsp1_valid", s_rsp_valid, 1);
    chk("t2_rsp1_rdata", s_rsp_rdata, 32'h1111_1111);
    chk("t2_rel_ready", s_req_ready, 1);
    chk("t2_rel_mvalid", m_req_valid, 2'b01);
    fall();
    req(1'b0, 1'b0, 32'h0, 32'h0);
    rsp(2'b01, 32'h2222_2222, 32'h0);
    #1;
    chk("t2_out1", outstanding, 1);
    fall();
    rsp(2'b00, 32'h0, 32'h0);
    #1;
    chk("t2_rsp0_valid", s_rsp_valid, 1);
    chk("t2_rsp0_rdata", s_rsp_rdata, 32'h2222_2222);
    chk("t2_out0", outstanding, 0);

    // 3: fill to MAX_OUTSTANDING with slave0 silent
    fall();
    req(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    for (int k = 1; k <= 3; k++) begin
      fall();
      #1;
      chk("t3_fill", outstanding, k);
    end
    fall();
    #1;
    chk("t3_full_out", outstanding, 4);
    chk("t3_full_ready", s_req_ready, 0);
    chk("t3_full_mvalid", m_req_valid, 2'b00);
    rsp(2'b01, 32'h3333_3333, 32'h0);
    #1;
    chk("t3_full_ready_rsp", s_req_ready, 0);
    fall();
    #1;
    chk("t3_drop_out", outstanding, 3);
    chk("t3_rsp_a", s_rsp_rdata, 32'h3333_3333);
    chk("t3_reopen_ready", s_req_ready, 1);
    rsp(2'b01, 32'h4444_4444, 32'h0);
    fall();
    #1;
    chk("t3_acc_rsp_same", outstanding, 3);
    chk("t3_rsp_b", s_rsp_rdata, 32'h4444_4444);
    rsp(2'b00, 32'h0, 32'h0);
    fall();
    #1;
    chk("t3_refull_out", outstanding, 4);
    chk("t3_refull_ready", s_req_ready, 0);
    req(1'b0, 1'b0, 32'h0, 32'h0);
    rsp(2'b01, 32'h5A5A_0000, 32'h0);
    for (int k = 3; k >= 0; k--) begin
      fall();
      #1;
      chk("t3_drain", outstanding, k);
    end
    // Response while nothing is in flight must be ignored
    fall();
    #1;
    chk("t3_idle_ignored", s_rsp_valid, 0);
    rsp(2'b00, 32'h0, 32'h0);

    // 4: unmapped read and write
    fall();
    req(1'b1, 1'b0, 32'h0002_0000, 32'h0);
    #1;
    chk("t4_rd_ready", s_req_ready, 1);
    chk("t4_rd_mvalid", m_req_valid, 2'b00);
    fall();
    req(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("t4_rd_decerr", decerr, 1);
    chk("t4_rd_rsp_valid", s_rsp_valid, 1);
    chk("t4_rd_rsp_rdata", s_rsp_rdata, 32'hDEAD_BEEF);
    chk("t4_rd_out", outstanding, 0);
    fall();
    req(1'b1, 1'b1, 32'h0003_0000, 32'h1234_5678);
    #1;
    chk("t4_decerr_pulse", decerr, 0);
    chk("t4_wr_ready", s_req_ready, 1);
    chk("t4_wr_mvalid", m_req_valid, 2'b00);
    fall();
    req(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("t4_wr_decerr", decerr, 1);
    chk("t4_wr_no_rsp", s_rsp_valid, 0);

    // 5: reset with two reads in flight to slave1
    fall();
    req(1'b1, 1'b0, 32'h0001_0000, 32'h0);
    fall();
    fall();
    req(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("t5_out2", outstanding, 2);
    #2;
    areset = 1'b1;
    req(1'b1, 1'b0, 32'h0001_0000, 32'h0);
    #1;
    chk("t5_rst_out", outstanding, 0);
    chk("t5_rst_rsp", s_rsp_valid, 0);
    chk("t5_rst_ready", s_req_ready, 0);
    chk("t5_rst_mvalid", m_req_valid, 2'b00);
    fall();
    areset = 1'b0;
    req(1'b0, 1'b0, 32'h0, 32'h0);
    rsp(2'b10, 32'h0, 32'hBAD0_BAD0);
    fall();
    rsp(2'b00, 32'h0, 32'h0);
    #1;
    chk("t5_late_ignored", s_rsp_valid, 0);
    chk("t5_late_out", outstanding, 0);
    fall();
    req(1'b1, 1'b0, 32'h0001_0004, 32'h0);
    #1;
    chk("t5_new_mvalid", m_req_valid, 2'b10);
    fall();
    req(1'b0, 1'b0, 32'h0, 32'h0);
    rsp(2'b10, 32'h0, 32'h5555_5555);
    #1;
    chk("t5_new_out", outstanding, 1);
    fall();
    rsp(2'b00, 32'h0, 32'h0);
    #1;
    chk("t5_new_rsp_valid", s_rsp_valid, 1);
    chk("t5_new_rsp_rdata", s_rsp_rdata, 32'h5555_5555);

    // 6: slave0 backpressure on a write
    fall();
    m_req_ready = 2'b10;
    req(1'b1, 1'b1, 32'h0000_0008, 32'h6666_6666);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t6_bp_ready", s_req_ready, 0);
      chk("t6_bp_mvalid", m_req_valid, 2'b01);
      chk("t6_bp_addr", m_req_addr, 32'h0000_0008);
      fall();
    end
    m_req_ready = 2'b11;
    #1;
    chk("t6_go_ready", s_req_ready, 1);
    chk("t6_go_wdata", m_req_wdata, 32'h6666_6666);
    fall();
    req(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("t6_wr_no_cnt", outstanding, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
